// File: rtl/jt12_wr_pkg.sv
// jt12_wr_sched shared definitions: register map, slot-op
// encoding, request bundle, decoder and hold-length helpers.
package jt12_wr_pkg;

  localparam logic [7:0] A_EFFECT = 8'h27;
  localparam logic [7:0] A_KEYON  = 8'h28;
  localparam logic [7:0] A_DT1    = 8'h30;
  localparam logic [7:0] A_TL     = 8'h40;
  localparam logic [7:0] A_KSAR   = 8'h50;
  localparam logic [7:0] A_AMDR   = 8'h60;
  localparam logic [7:0] A_SR     = 8'h70;
  localparam logic [7:0] A_SLRR   = 8'h80;
  localparam logic [7:0] A_SSG    = 8'h90;
  localparam logic [7:0] A_FNLO   = 8'hA0;
  localparam logic [7:0] A_FNHI   = 8'hA4;
  localparam logic [7:0] A_CH3F   = 8'hA8;
  localparam logic [7:0] A_CH3HI  = 8'hAC;
  localparam logic [7:0] A_ALG    = 8'hB0;
  localparam logic [7:0] A_PMS    = 8'hB4;

  typedef enum logic [1:0] {
    OP_S1 = 2'd0,
    OP_S3 = 2'd1,
    OP_S2 = 2'd2,
    OP_S4 = 2'd3
  } op_t;

  typedef enum logic [3:0] {
    K_NONE,
    K_KEYON,
    K_DT1,
    K_TL,
    K_KSAR,
    K_AMDR,
    K_SR,
    K_SLRR,
    K_SSG,
    K_FNLO,
    K_ALG,
    K_PMS,
    K_FNHI,
    K_FNHI3,
    K_CH3F,
    K_EFFECT
  } kind_t;

  typedef struct packed {
    logic [7:0] addr;
    logic       part;
    logic [7:0] data;
  } wr_t;

  function automatic int unsigned hold_len(
    input int unsigned n
  );
    return 4 * n;
  endfunction

  // Kinds below K_FNHI go through HOLD.
  function automatic logic is_update(
    input kind_t k
  );
    return (k != K_NONE) && (k < K_FNHI);
  endfunction

  function automatic kind_t decode(
    input logic [7:0] a,
    input logic       part,
    input logic       drop_p1
  );
    kind_t k;
    logic  bad;
    bad = (a[1:0] == 2'd3);
    k   = K_NONE;
    if (!(drop_p1 && part)) begin
      unique case (1'b1)
        a == A_EFFECT:
          k = K_EFFECT;
        a == A_KEYON:
          k = part ? K_NONE : K_KEYON;
        a[7:4] == A_DT1[7:4]:
          k = bad ? K_NONE : K_DT1;
        a[7:4] == A_TL[7:4]:
          k = bad ? K_NONE : K_TL;
        a[7:4] == A_KSAR[7:4]:
          k = bad ? K_NONE : K_KSAR;
        a[7:4] == A_AMDR[7:4]:
          k = bad ? K_NONE : K_AMDR;
        a[7:4] == A_SR[7:4]:
          k = bad ? K_NONE : K_SR;
        a[7:4] == A_SLRR[7:4]:
          k = bad ? K_NONE : K_SLRR;
        a[7:4] == A_SSG[7:4]:
          k = bad ? K_NONE : K_SSG;
        a[7:2] == A_FNLO[7:2]:
          k = bad ? K_NONE : K_FNLO;
        a[7:2] == A_FNHI[7:2]:
          k = bad ? K_NONE : K_FNHI;
        a[7:2] == A_CH3F[7:2]:
          k = (bad || part) ? K_NONE : K_CH3F;
        a[7:2] == A_CH3HI[7:2]:
          k = bad ? K_NONE : K_FNHI3;
        a[7:2] == A_ALG[7:2]:
          k = bad ? K_NONE : K_ALG;
        a[7:2] == A_PMS[7:2]:
          k = bad ? K_NONE : K_PMS;
        default:
          k = K_NONE;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/jt12_wr_sched_if.sv
// CPU write bus into jt12_wr_sched.
// cpu_wr pulse, cpu_a {part, addr/data}, cpu_din.
interface jt12_wr_sched_if;
  logic       cpu_wr;
  logic [1:0] cpu_a;
  logic [7:0] cpu_din;

  modport master (
    output cpu_wr,
    output cpu_a,
    output cpu_din
  );

  modport slave (
    input cpu_wr,
    input cpu_a,
    input cpu_din
  );
endinterface

// File: rtl/jt12_wr_fifo.sv
// 4-deep write queue. push/din in, pop/dout/empty/full out.
// A push into a full queue is dropped.
module jt12_wr_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [4];
  logic [1:0]   wp;
  logic [1:0]   rp;
  logic [2:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign empty   = (cnt == 3'd0);
  assign full    = (cnt == 3'd4);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < 4; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + 2'd1;
      end
      if (do_pop)
        rp <= rp + 2'd1;
      if (do_push && !do_pop)
        cnt <= cnt + 3'd1;
      else if (!do_push && do_pop)
        cnt <= cnt - 3'd1;
    end
  end
endmodule

// File: rtl/jt12_wr_sched.sv
// Register-write scheduler: decodes CPU writes into a held up_* strobe.
// Ports: clk, rst_n, clk_en, bus (slave), busy/din/ch/op/up_*, FNUM/CH3/effect regs. Optional JT12_WRQUEUE_EN.
module jt12_wr_sched
  import jt12_wr_pkg::*;
#(
  parameter int num_ch = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  jt12_wr_sched_if.slave bus,
  output logic        busy,
  output logic [7:0]  din,
  output logic [2:0]  ch,
  output logic [1:0]  op,
  output logic        up_keyon,
  output logic        up_alg,
  output logic        up_fnumlo,
  output logic        up_pms,
  output logic        up_dt1,
  output logic        up_tl,
  output logic        up_ks_ar,
  output logic        up_amen_dr,
  output logic        up_sr,
  output logic        up_sl_rr,
  output logic        up_ssgeg,
  output logic [5:0]  latch_fnum,
  output logic        effect,
  output logic [10:0] fnum_ch3op1,
  output logic [10:0] fnum_ch3op2,
  output logic [10:0] fnum_ch3op3,
  output logic [2:0]  block_ch3op1,
  output logic [2:0]  block_ch3op2,
  output logic [2:0]  block_ch3op3
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [4:0] LOAD =
    5'(hold_len(num_ch) - 1);
  localparam logic DROP_P1 = (num_ch == 3);

  logic [0:0]  st;
  logic [4:0]  cnt;
  kind_t       kind_q;
  op_t         op_q;
  logic [7:0]  addr_q;
  logic        part_q;
  logic [5:0]  fhi_q;
  logic [5:0]  fhi3_q;
  logic [13:0] c3op1;
  logic [13:0] c3op2;
  logic [13:0] c3op3;
  wr_t         req;
  logic        req_v;
  kind_t       k;
  logic        hold;
  logic        go;
  logic        addr_wr;
  logic        data_wr;

  assign addr_wr = bus.cpu_wr & ~bus.cpu_a[0];
  assign data_wr = bus.cpu_wr & bus.cpu_a[0];
  assign hold    = (st == HOLD);

`ifdef JT12_WRQUEUE_EN
  logic q_empty;
  logic q_full;
  wr_t  q_head;

  jt12_wr_fifo #(
    .W($bits(wr_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (data_wr & ~q_full),
    .din   ({addr_q, part_q, bus.cpu_din}),
    .pop   (~hold),
    .dout  (q_head),
    .empty (q_empty),
    .full  (q_full)
  );

  assign req   = q_head;
  assign req_v = ~hold & ~q_empty;
  assign busy  = hold | ~q_empty;
`else
  // The chip ignores data writes while busy.
  assign req   = '{addr: addr_q,
                   part: part_q,
                   data: bus.cpu_din};
  assign req_v = data_wr & ~hold;
  assign busy  = hold;
`endif

  assign k  = decode(req.addr, req.part, DROP_P1);
  assign go = req_v & is_update(k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      cnt        <= '0;
      kind_q     <= K_NONE;
      din        <= '0;
      ch         <= '0;
      op_q       <= OP_S1;
      latch_fnum <= '0;
    end else if (hold) begin
      if (clk_en) begin
        if (cnt == 5'd0)
          st <= IDLE;
        else
          cnt <= cnt - 5'd1;
      end
    end else if (go) begin
      st     <= HOLD;
      cnt    <= LOAD;
      kind_q <= k;
      din    <= req.data;
      ch     <= {req.part, req.addr[1:0]};
      op_q   <= op_t'(req.addr[3:2]);
      if (k == K_FNLO)
        latch_fnum <= fhi_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      part_q <= 1'b0;
      fhi_q  <= '0;
      fhi3_q <= '0;
      effect <= 1'b0;
      c3op1  <= '0;
      c3op2  <= '0;
      c3op3  <= '0;
    end else begin
      if (addr_wr) begin
        addr_q <= bus.cpu_din;
        part_q <= bus.cpu_a[1];
      end
      if (req_v) begin
        case (k)
          K_FNHI:   fhi_q  <= req.data[5:0];
          K_FNHI3:  fhi3_q <= req.data[5:0];
          K_EFFECT: effect <= req.data[6];
          K_CH3F: begin
            // A8 -> op3, A9 -> op1, AA -> op2
            case (req.addr[1:0])
              2'd0:    c3op3 <= {fhi3_q, req.data};
              2'd1:    c3op1 <= {fhi3_q, req.data};
              2'd2:    c3op2 <= {fhi3_q, req.data};
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign op           = op_q;
  assign up_keyon     = hold && kind_q == K_KEYON;
  assign up_dt1       = hold && kind_q == K_DT1;
  assign up_tl        = hold && kind_q == K_TL;
  assign up_ks_ar     = hold && kind_q == K_KSAR;
  assign up_amen_dr   = hold && kind_q == K_AMDR;
  assign up_sr        = hold && kind_q == K_SR;
  assign up_sl_rr     = hold && kind_q == K_SLRR;
  assign up_ssgeg     = hold && kind_q == K_SSG;
  assign up_fnumlo    = hold && kind_q == K_FNLO;
  assign up_alg       = hold && kind_q == K_ALG;
  assign up_pms       = hold && kind_q == K_PMS;

  assign fnum_ch3op1  = c3op1[10:0];
  assign fnum_ch3op2  = c3op2[10:0];
  assign fnum_ch3op3  = c3op3[10:0];
  assign block_ch3op1 = c3op1[13:11];
  assign block_ch3op2 = c3op2[13:11];
  assign block_ch3op3 = c3op3[13:11];
endmodule

// File: doc/jt12_wr_sched.md
# jt12_wr_sched

Register-write scheduler sitting between the CPU bus interface and the operator/channel register block. It latches address/data writes and decodes them into one `up_*` strobe plus `ch`/`op`/`din`. It holds that request stable for one full slot rotation, so every pipeline-stage comparator in the register block sees it exactly once, and reports `busy` while doing so. It also owns the FNUM-high latches, the CH3 special-mode frequency registers and the effect-mode bit.

## Interface
Parameters:
- `num_ch`, default 6: channel count, 6 or 3. Rotation length is `4*num_ch` slots.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk_en` in 1: slot-advance enable, shared with the register block.
- `cpu_wr` in 1: one-cycle write pulse, sampled on `clk` without `clk_en` gating.
- `cpu_a` in 2: bit0 selects address (0) or data (1); bit1 selects part (0 = ch 0-2, 1 = ch 3-5).
- `cpu_din` in 8: write data.
- `busy` out 1: a register update is in progress.
- `din` out 8: held data to the register block.
- `ch` out 3: target channel in slot encoding, values {0,1,2,4,5,6}.
- `op` out 2: target operator in slot order (0 = S1, 1 = S3, 2 = S2, 3 = S4).
- `up_keyon`, `up_alg`, `up_fnumlo`, `up_pms`, `up_dt1`, `up_tl`, `up_ks_ar`, `up_amen_dr`, `up_sr`, `up_sl_rr`, `up_ssgeg` out 1 each: update strobes, at most one high at a time.
- `latch_fnum` out 6: {block[2:0], fnum[10:8]} captured when an FNUM-low write is accepted.
- `effect` out 1: CH3 special mode.
- `fnum_ch3op1`, `fnum_ch3op2`, `fnum_ch3op3` out 11 each.
- `block_ch3op1`, `block_ch3op2`, `block_ch3op3` out 3 each.

## Operation
- Address write (`cpu_a[0]=0`): `addr_q <= cpu_din`, `part_q <= cpu_a[1]`. Address writes are always accepted, including while busy; held outputs are not affected.
- Data write (`cpu_a[0]=1`): decoded from `addr_q` and `part_q`.
  - `ch = {part_q, addr_q[1:0]}`; `op = addr_q[3:2]`.
  - `addr_q[1:0]==3` on any per-channel register: write ignored.
  - With `num_ch==3`, every part-1 write is ignored.
- Update registers. Each one enters HOLD.
  - 0x28, part 0 only: `up_keyon`.
  - 0x30-0x3F `up_dt1`; 0x40 `up_tl`; 0x50 `up_ks_ar`; 0x60 `up_amen_dr`; 0x70 `up_sr`; 0x80 `up_sl_rr`; 0x90 `up_ssgeg`.
  - 0xA0-A2 `up_fnumlo`, with `latch_fnum <= fhi_q`.
  - 0xB0-B2 `up_alg`; 0xB4-B6 `up_pms`.
- Immediate registers. These take effect on the accept edge, with no HOLD and no `busy`.
  - 0xA4-A6: `fhi_q <= cpu_din[5:0]`. This latch is shared by all channels.
  - 0xAC-AE: `fhi3_q <= cpu_din[5:0]`.
  - 0xA8/A9/AA (part 0): `{block,fnum}` of ch3op3 / ch3op1 / ch3op2 `<= {fhi3_q, cpu_din}`.
  - 0x27: `effect <= cpu_din[6]`.
- All other addresses are ignored.
- FSM states:
  - IDLE: all `up_*` are 0.
  - HOLD: exactly one `up_*` is 1; `din`, `ch`, `op` are frozen.
  - IDLE→HOLD on an accepted update write. The down-counter is loaded with `4*num_ch-1`.
  - The counter decrements on each `clk_en`.
  - HOLD→IDLE on `clk_en` with counter==0.
- Reset values: `busy`=0, all `up_*`=0, `din`=0, `ch`=0, `op`=0, `latch_fnum`=0, `effect`=0, all ch3 fnum/block=0, `addr_q`=0, `fhi_q`=0, `fhi3_q`=0.
- Reset during HOLD: the pending write is lost and the FSM returns to IDLE asynchronously.

## Timing
- Accept edge T. `up_*`, `din`, `ch`, `op` and `busy` are valid from T+1.
- HOLD covers exactly `4*num_ch` `clk_en` pulses: the first pulse at or after T+1, through the last one.
- `busy` falls on the edge that consumes the final `clk_en`.
- Data write with `busy`=1, including the last HOLD cycle: handling depends on configuration (below).
- `clk_en` held low: HOLD is extended indefinitely; nothing times out.

## Configuration
- `JT12_WRQUEUE_EN` defined:
  - A 4-entry FIFO of {addr, part, data} sits in front of the decoder.
  - Data writes are pushed unconditionally; a push when full is dropped.
  - `busy` = HOLD or FIFO non-empty.
  - Pop happens in IDLE, one entry per `clk`.
  - Immediate registers are applied in FIFO order.
- Not defined:
  - No FIFO.
  - A data write while `busy`=1 is dropped, matching chip behaviour.
  - An immediate register write while `busy`=1 is also dropped.

## Structure
- Package `jt12_wr_pkg`:
  - Register address constants (0x27, 0x28, 0x30…0xB4).
  - Slot-op encoding.
  - Hold-length function `4*num_ch`.
- Sub-module `jt12_wr_fifo` (4×17-bit, synchronous, async-reset), instantiated only under `JT12_WRQUEUE_EN`.

## Test plan
- Addr 0x42 part 1, data 0x7F → `up_tl`=1, `ch`=6, `op`=0, `din`=0x7F for exactly 24 `clk_en`; `busy` spans the same window.
- Data 0x22 to 0xA5, then data 0x34 to 0xA1 → no HOLD for the 0xA5 write; `up_fnumlo` with `ch`=1, `latch_fnum`=0x22, `din`=0x34.
- Data 0x0D to 0xAC, then data 0x80 to 0xA9 → `block_ch3op1`=1, `fnum_ch3op1`=0x580; no `busy`.
- Without the macro: second data write during HOLD is dropped and the outputs are unchanged. With the macro: the same sequence yields two back-to-back HOLDs with `busy` continuous.
- Data to 0x43 (ch field 3), and `num_ch=3` part-1 write → no strobe, `busy` stays 0.
- `rst_n` low mid-HOLD → all outputs at reset values immediately; the next write behaves normally.
